// File: rtl/nbr_pkg.sv
// Shared types and constants for the 3x3 neighbourhood window fetcher.
// Slot order runs C, N, NE, E, SE, S, SW, W, NW around the centre pixel.
package nbr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [3:0] SLOT_C  = 4'd0;
  localparam logic [3:0] SLOT_N  = 4'd1;
  localparam logic [3:0] SLOT_NE = 4'd2;
  localparam logic [3:0] SLOT_E  = 4'd3;
  localparam logic [3:0] SLOT_SE = 4'd4;
  localparam logic [3:0] SLOT_S  = 4'd5;
  localparam logic [3:0] SLOT_SW = 4'd6;
  localparam logic [3:0] SLOT_W  = 4'd7;
  localparam logic [3:0] SLOT_NW = 4'd8;

  localparam int NUM_SLOTS = 9;
  localparam int PIX_W     = 8;
  localparam int WIN_W     = 72;

  // Row and column offsets of each slot relative to the centre pixel.
  localparam logic signed [1:0] DR [NUM_SLOTS] = '{
    2'sd0, -2'sd1, -2'sd1, 2'sd0, 2'sd1, 2'sd1, 2'sd1, 2'sd0, -2'sd1
  };
  localparam logic signed [1:0] DC [NUM_SLOTS] = '{
    2'sd0, 2'sd0, 2'sd1, 2'sd1, 2'sd1, 2'sd0, -2'sd1, -2'sd1, -2'sd1
  };

  function automatic logic is_last_slot(input logic [3:0] k);
    return k == SLOT_NW;
  endfunction

endpackage

// File: rtl/nbr_window_fetch_if.sv
// RAM read port plus the downstream window valid/ready channel.
// master is the fetcher side, slave is the RAM/consumer side.
interface nbr_window_fetch_if #(
  parameter int AW = 7
) ();

  logic [AW-1:0]             rd_addr;
  logic [7:0]                rd_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [nbr_pkg::WIN_W-1:0] out_window;
  logic [AW-1:0]             out_addr;
  logic                      out_last;

  modport master (
    output rd_addr,
    input  rd_data,
    output out_valid,
    input  out_ready,
    output out_window,
    output out_addr,
    output out_last
  );

  modport slave (
    input  rd_addr,
    output rd_data,
    input  out_valid,
    output out_ready,
    input  out_window,
    input  out_addr,
    input  out_last
  );

endinterface

// File: rtl/nbr_addr_gen.sv
// Combinational neighbour address for (row, col, slot k) with an out-of-image flag.
// Row/col are widened with a sign bit and a guard bit so both -1 and N are distinguishable.
module nbr_addr_gen
  import nbr_pkg::*;
#(
  parameter int N       = 8,
  parameter int bitSize = 6,
  localparam int RW     = $clog2(N),
  localparam int AW     = bitSize + 1
) (
  input  logic [RW-1:0] row,
  input  logic [RW-1:0] col,
  input  logic [3:0]    k,
  output logic [AW-1:0] addr,
  output logic          in_bounds
);

  localparam int SW = RW + 2;
  localparam logic signed [SW-1:0] LIM = SW'(N);
  localparam logic [AW-1:0] NA = AW'(N);

  logic signed [1:0]    dr;
  logic signed [1:0]    dc;
  logic signed [SW-1:0] rs;
  logic signed [SW-1:0] cs;
  logic                 row_ok;
  logic                 col_ok;

  always_comb begin
    dr = 2'sd0;
    dc = 2'sd0;
    if (k <= SLOT_NW) begin
      dr = DR[k];
      dc = DC[k];
    end
    rs = signed'({2'b00, row}) + SW'(dr);
    cs = signed'({2'b00, col}) + SW'(dc);
    row_ok    = !rs[SW-1] && (rs < LIM);
    col_ok    = !cs[SW-1] && (cs < LIM);
    in_bounds = row_ok && col_ok;
    addr      = AW'(unsigned'(rs)) * NA + AW'(unsigned'(cs));
  end

endmodule

// File: rtl/nbr_window_fetch.sv
// Raster-scans the N x N image, fetching nine neighbour pixels per centre (one per cycle),
// then presents the 72-bit window and holds it until out_ready; 10 cycles per pixel at full rate.
module nbr_window_fetch
  import nbr_pkg::*;
#(
  parameter int N       = 8,
  parameter int bitSize = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  nbr_window_fetch_if.master bus
);

  localparam int RW = $clog2(N);
  localparam int AW = bitSize + 1;
  localparam logic [RW-1:0] COL_MAX = RW'(N - 1);
  localparam logic [AW-1:0] NA      = AW'(N);
  localparam logic [AW-1:0] LAST    = AW'(N * N - 1);

  state_t            state;
  state_t            state_n;
  logic [RW-1:0]     row;
  logic [RW-1:0]     col;
  logic [3:0]        k;
  logic [WIN_W-1:0]  gather_q;
  logic [WIN_W-1:0]  win_next;
  logic [WIN_W-1:0]  win_q;
  logic [AW-1:0]     addr_q;
  logic              last_q;
  logic [AW-1:0]     rd_addr_q;
  logic [AW-1:0]     rd_addr_c;
  logic [AW-1:0]     gen_addr;
  logic [AW-1:0]     pix_addr;
  logic              gen_inb;
  logic [PIX_W-1:0]  slot_dat;
  logic              fetch_end;
  logic              xfer;

  nbr_addr_gen #(
    .N       (N),
    .bitSize (bitSize)
  ) u_addr_gen (
    .row       (row),
    .col       (col),
    .k         (k),
    .addr      (gen_addr),
    .in_bounds (gen_inb)
  );

  assign pix_addr = AW'(row) * NA + AW'(col);

  always_comb begin
    state_n   = state;
    rd_addr_c = rd_addr_q;
    slot_dat  = gen_inb ? bus.rd_data : 8'h00;
    win_next  = gather_q;
    win_next[WIN_W-1 -: PIX_W] = slot_dat;
    fetch_end = (state == FETCH) && is_last_slot(k);
    xfer      = (state == PRESENT) && bus.out_ready;
    case (state)
      IDLE: begin
        if (start) state_n = FETCH;
      end
      FETCH: begin
        // Out-of-image slots leave the RAM address where it was.
        if (gen_inb) rd_addr_c = gen_addr;
        if (is_last_slot(k)) state_n = PRESENT;
      end
      PRESENT: begin
        if (bus.out_ready) state_n = last_q ? DONE : FETCH;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      k         <= '0;
      gather_q  <= '0;
      win_q     <= '0;
      addr_q    <= '0;
      last_q    <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      state     <= state_n;
      rd_addr_q <= rd_addr_c;
      case (state)
        IDLE: begin
          if (start) begin
            row <= '0;
            col <= '0;
            k   <= '0;
          end
        end
        FETCH: begin
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (k == 4'(i)) gather_q[PIX_W*i +: PIX_W] <= slot_dat;
          end
          if (fetch_end) begin
            k      <= '0;
            win_q  <= win_next;
            addr_q <= pix_addr;
            last_q <= (pix_addr == LAST);
          end else begin
            k <= k + 4'd1;
          end
        end
        PRESENT: begin
          if (xfer && !last_q) begin
            if (col == COL_MAX) begin
              col <= '0;
              row <= row + RW'(1);
            end else begin
              col <= col + RW'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy           = (state == FETCH) || (state == PRESENT);
  assign done           = (state == DONE);
  assign bus.rd_addr    = rd_addr_c;
  assign bus.out_valid  = (state == PRESENT);
  assign bus.out_window = win_q;
  assign bus.out_addr   = addr_q;
  assign bus.out_last   = last_q && (state == PRESENT);

endmodule

// File: tb/tb_nbr_window_fetch.sv
// Bench for nbr_window_fetch: RAM model plus a 2-D neighbourhood reference computed from row/col arithmetic.
module tb_nbr_window_fetch;

  localparam int N    = 8;
  localparam int BS   = 6;
  localparam int AW   = BS + 1;
  localparam int NPIX = N * N;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic done;
  int   cyc          = 0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  logic [7:0] mem [2**AW];
  int dr_t [9] = '{0, -1, -1, 0, 1, 1, 1, 0, -1};
  int dc_t [9] = '{0, 0, 1, 1, 1, 0, -1, -1, -1};

  nbr_window_fetch_if #(.AW(AW)) bus ();

  nbr_window_fetch #(.N(N), .bitSize(BS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign bus.rd_data = mem[bus.rd_addr];

  function automatic logic [71:0] exp_win(input int p);
    logic [71:0] w;
    int r, c;
    w = '0;
    for (int s = 0; s < 9; s++) begin
      r = p / N + dr_t[s];
      c = p % N + dc_t[s];
      if (r >= 0 && r < N && c >= 0 && c < N) w[8*s +: 8] = mem[r*N + c];
    end
    return w;
  endfunction

  function automatic logic [71:0] pack9(input int v [9]);
    logic [71:0] w;
    for (int s = 0; s < 9; s++) w[8*s +: 8] = 8'(v[s]);
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; bus.out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start(output int t);
    start = 1'b1;
    tick();
    start = 1'b0;
    t = cyc;
  endtask

  task automatic fill_identity();
    for (int a = 0; a < 2**AW; a++) mem[a] = 8'(a);
  endtask

  task automatic fill_random();
    for (int a = 0; a < 2**AW; a++) mem[a] = 8'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bus.out_ready = 1'b0;
    fill_identity();
    tick(); tick();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %0b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %0b want 0", done); end
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %0b want 0", bus.out_valid); end
    tests_run++; if (bus.out_last !== 1'b0) begin tests_failed++; $display("FAIL reset_last got %0b want 0", bus.out_last); end
    tests_run++; if (bus.rd_addr !== '0) begin tests_failed++; $display("FAIL reset_rd_addr got %0d want 0", bus.rd_addr); end
    tests_run++; if (bus.out_window !== '0) begin tests_failed++; $display("FAIL reset_window got %h want 0", bus.out_window); end
    tests_run++; if (bus.out_addr !== '0) begin tests_failed++; $display("FAIL reset_out_addr got %0d want 0", bus.out_addr); end
    rst = 1'b0;
    tick();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL idle_busy got %0b want 0", busy); end
  endtask

  task automatic test_full_scan();
    int t, n_xfer, n_done, last_edge, first_valid, p;
    logic prev_busy, start_sent;
    int v [9];
    fill_identity();
    do_reset();
    bus.out_ready = 1'b1;
    pulse_start(t);
    n_xfer = 0; n_done = 0; last_edge = -1; first_valid = -1; start_sent = 1'b0; prev_busy = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (bus.out_valid && first_valid < 0) first_valid = cyc;
      if (done) begin
        n_done++;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL done_busy got %0b want 0", busy); end
        tests_run++; if (prev_busy !== 1'b1) begin tests_failed++; $display("FAIL busy_before_done got %0b want 1", prev_busy); end
        tests_run++; if (cyc != last_edge) begin tests_failed++; $display("FAIL done_timing got %0d want %0d", cyc, last_edge); end
      end
      if (bus.out_valid) begin
        p = n_xfer;
        tests_run++; if (bus.out_addr !== AW'(p)) begin tests_failed++; $display("FAIL scan_addr got %0d want %0d", bus.out_addr, p); end
        tests_run++; if (bus.out_window !== exp_win(p)) begin tests_failed++; $display("FAIL scan_window p=%0d got %h want %h", p, bus.out_window, exp_win(p)); end
        tests_run++; if (bus.out_last !== (p == NPIX-1)) begin tests_failed++; $display("FAIL scan_last p=%0d got %0b", p, bus.out_last); end
        tests_run++; if (cyc + 1 != t + 10 + 10*p) begin tests_failed++; $display("FAIL scan_timing p=%0d got %0d want %0d", p, cyc + 1 - t, 10 + 10*p); end
        if (p == 0) begin
          v = '{0, 0, 0, 1, 9, 8, 0, 0, 0};
          tests_run++; if (bus.out_window !== pack9(v)) begin tests_failed++; $display("FAIL pix0_window got %h want %h", bus.out_window, pack9(v)); end
        end
        if (p == 9) begin
          v = '{9, 1, 2, 10, 18, 17, 16, 8, 0};
          tests_run++; if (bus.out_window !== pack9(v)) begin tests_failed++; $display("FAIL pix9_window got %h want %h", bus.out_window, pack9(v)); end
        end
        if (p == 63) begin
          v = '{63, 55, 0, 0, 0, 0, 0, 62, 54};
          tests_run++; if (bus.out_window !== pack9(v)) begin tests_failed++; $display("FAIL pix63_window got %h want %h", bus.out_window, pack9(v)); end
        end
        if (bus.out_last) last_edge = cyc + 1;
        n_xfer++;
      end
      start = (n_xfer == 12) && !start_sent;
      if (start) start_sent = 1'b1;
      prev_busy = busy;
      tick();
      if (last_edge > 0 && cyc > last_edge + 3) break;
    end
    start = 1'b0;
    tests_run++; if (first_valid != t + 9) begin tests_failed++; $display("FAIL first_valid_latency got %0d want 9", first_valid - t); end
    tests_run++; if (n_xfer != NPIX) begin tests_failed++; $display("FAIL scan_count got %0d want %0d", n_xfer, NPIX); end
    tests_run++; if (n_done != 1) begin tests_failed++; $display("FAIL done_count got %0d want 1", n_done); end
  endtask

  task automatic test_stall();
    int t, n_xfer, stall, e5, p;
    logic rdy, done_seen;
    logic [71:0] snap_w;
    logic [AW-1:0] snap_a, snap_r;
    fill_random();
    do_reset();
    bus.out_ready = 1'b1;
    pulse_start(t);
    n_xfer = 0; stall = 0; e5 = -1; done_seen = 1'b0; snap_w = '0; snap_a = '0; snap_r = '0;
    for (int i = 0; i < 900; i++) begin
      if (done) begin done_seen = 1'b1; break; end
      rdy = 1'b1;
      if (bus.out_valid && bus.out_addr == AW'(5) && stall < 20) begin
        rdy = 1'b0;
        if (stall == 0) begin
          snap_w = bus.out_window; snap_a = bus.out_addr; snap_r = bus.rd_addr;
        end else begin
          tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_valid got %0b want 1", bus.out_valid); end
          tests_run++; if (bus.out_window !== snap_w) begin tests_failed++; $display("FAIL stall_window got %h want %h", bus.out_window, snap_w); end
          tests_run++; if (bus.out_addr !== snap_a) begin tests_failed++; $display("FAIL stall_addr got %0d want %0d", bus.out_addr, snap_a); end
          tests_run++; if (bus.rd_addr !== snap_r) begin tests_failed++; $display("FAIL stall_rd_addr got %0d want %0d", bus.rd_addr, snap_r); end
        end
        stall++;
      end
      bus.out_ready = rdy;
      if (bus.out_valid && rdy) begin
        p = n_xfer;
        tests_run++; if (bus.out_addr !== AW'(p)) begin tests_failed++; $display("FAIL stall_seq got %0d want %0d", bus.out_addr, p); end
        tests_run++; if (bus.out_window !== exp_win(p)) begin tests_failed++; $display("FAIL stall_scan_window p=%0d got %h want %h", p, bus.out_window, exp_win(p)); end
        if (p == 5) e5 = cyc + 1;
        if (p == 6) begin
          tests_run++; if (cyc != e5 + 9) begin tests_failed++; $display("FAIL release_latency got %0d want 10", cyc + 1 - e5); end
        end
        n_xfer++;
      end
      tick();
    end
    tests_run++; if (stall != 20) begin tests_failed++; $display("FAIL stall_cycles got %0d want 20", stall); end
    tests_run++; if (n_xfer != NPIX) begin tests_failed++; $display("FAIL stall_count got %0d want %0d", n_xfer, NPIX); end
    tests_run++; if (done_seen !== 1'b1) begin tests_failed++; $display("FAIL stall_done got %0b want 1", done_seen); end
  endtask

  task automatic test_midscan_reset();
    int t, n_xfer;
    fill_identity();
    do_reset();
    bus.out_ready = 1'b1;
    pulse_start(t);
    n_xfer = 0;
    for (int i = 0; i < 400 && n_xfer < 30; i++) begin
      if (bus.out_valid) n_xfer++;
      tick();
    end
    tick(); tick(); tick();
    tests_run++; if (busy !== 1'b1 || bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL pre_reset_fetch got busy=%0b valid=%0b want 1/0", busy, bus.out_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++; if (busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_status got busy=%0b done=%0b want 0/0", busy, done); end
    tests_run++; if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_valid got %0b/%0b want 0/0", bus.out_valid, bus.out_last); end
    tests_run++; if (bus.rd_addr !== '0) begin tests_failed++; $display("FAIL mid_reset_rd_addr got %0d want 0", bus.rd_addr); end
    tests_run++; if (bus.out_window !== '0 || bus.out_addr !== '0) begin tests_failed++; $display("FAIL mid_reset_window got %h/%0d want 0/0", bus.out_window, bus.out_addr); end
    tick();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_idle got %0b want 0", busy); end
    pulse_start(t);
    repeat (8) tick();
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL restart_early_valid got %0b want 0", bus.out_valid); end
    tick();
    tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL restart_valid got %0b want 1", bus.out_valid); end
    tests_run++; if (bus.out_addr !== '0 || bus.out_window !== exp_win(0)) begin tests_failed++; $display("FAIL restart_window got %h@%0d want %h@0", bus.out_window, bus.out_addr, exp_win(0)); end
  endtask

  task automatic test_random_ready();
    int t, n_xfer, n_done, done_cyc;
    logic rdy;
    fill_random();
    do_reset();
    pulse_start(t);
    n_xfer = 0; n_done = 0; done_cyc = -1;
    for (int i = 0; i < 4000; i++) begin
      if (done) begin n_done++; done_cyc = cyc; end
      if (done_cyc > 0 && cyc > done_cyc + 3) break;
      rdy = 1'($urandom_range(0, 1));
      bus.out_ready = rdy;
      if (bus.out_valid && rdy) begin
        tests_run++; if (bus.out_addr !== AW'(n_xfer)) begin tests_failed++; $display("FAIL rand_seq got %0d want %0d", bus.out_addr, n_xfer); end
        tests_run++; if (bus.out_last !== (n_xfer == NPIX-1)) begin tests_failed++; $display("FAIL rand_last at %0d got %0b", n_xfer, bus.out_last); end
        tests_run++; if (bus.out_window !== exp_win(n_xfer)) begin tests_failed++; $display("FAIL rand_window p=%0d got %h want %h", n_xfer, bus.out_window, exp_win(n_xfer)); end
        n_xfer++;
      end
      tick();
    end
    bus.out_ready = 1'b0;
    tests_run++; if (n_xfer != NPIX) begin tests_failed++; $display("FAIL rand_count got %0d want %0d", n_xfer, NPIX); end
    tests_run++; if (n_done != 1) begin tests_failed++; $display("FAIL rand_done_count got %0d want 1", n_done); end
  endtask

  initial begin
    bus.out_ready = 1'b0;
    test_reset();
    test_full_scan();
    test_stall();
    test_midscan_reset();
    test_random_ready();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/nbr_window_fetch.md
Name: nbr_window_fetch

Overview:
- Read-side client of the image RAM used by the skeletonization datapath.
- After a start pulse it scans the N×N image in raster order through the RAM's dual (read-only) port.
- For each pixel it gathers the 3×3 neighbourhood and presents it downstream over a valid/ready handshake.
- The thinning stage consumes these windows; this block never writes the RAM.

Parameters:
- N, 8, image side length in pixels; image occupies RAM addresses 0..N*N-1.
- bitSize, 6, address MSB index; address width is bitSize+1 and must satisfy 2^(bitSize+1) >= N*N.

Ports:
- clk  in  1  rising-edge clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a full-image scan; ignored unless idle.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last window is transferred.
- rd_addr  out  bitSize+1  address driven to the RAM dual read port.
- rd_data  in  8  RAM dual-port read data; combinational, valid in the same cycle as rd_addr.
- out_valid  out  1  window available.
- out_ready  in  1  downstream accepts the window.
- out_window  out  72  nine 8-bit pixels; slot k is bits [8k+7:8k].
- out_addr  out  bitSize+1  address of the centre pixel of out_window.
- out_last  out  1  high with out_valid when out_addr = N*N-1.

Behaviour:
- Reset (sync, rst=1 at an edge) puts every output at 0: busy, done, out_valid, out_last, rd_addr, out_window, out_addr. Row/col/slot counters go to 0 and the state goes to IDLE. This applies in any state, including mid-scan or while a window is stalled; the pending window is discarded.
- Neighbour slot order, k = 0..8, as (dr,dc):
  - 0: C (0,0)
  - 1: N (-1,0)
  - 2: NE (-1,+1)
  - 3: E (0,+1)
  - 4: SE (+1,+1)
  - 5: S (+1,0)
  - 6: SW (+1,-1)
  - 7: W (0,-1)
  - 8: NW (-1,-1)
- Address arithmetic:
  - Neighbour address = (row+dr)*N + (col+dc).
  - Computed with row/col extended by one sign bit so that -1 and N are detectable.
  - If row+dr or col+dc falls outside 0..N-1, the slot is out of bounds: it is captured as 8'h00 and rd_addr holds its previous value. It still consumes its cycle.
- FSM states:
  - IDLE: busy=0. start=1 at edge t moves to FETCH at t+1, with row=col=k=0. start is ignored in every other state.
  - FETCH: one slot per cycle. rd_addr is driven combinationally from (row,col,k) and rd_data is captured into slot k at the end of the cycle. After k=8 the state goes to PRESENT, out_window/out_addr are loaded, and out_valid=1.
  - PRESENT: out_valid, out_window, out_addr and out_last are held stable while out_ready=0. When out_valid&&out_ready at an edge:
    - if not the last pixel: advance col, wrapping to 0 with row+1 when col=N-1, and go to FETCH.
    - if the last pixel: go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Timing:
  - With start accepted at edge t and out_ready held high, pixel p is valid during cycle t+10+10p.
  - For N=8 the last transfer is at t+640 and done pulses in cycle t+641.
- Timing is identical whether or not slots are out of bounds: always 9 fetch cycles per pixel.
- out_ready while out_valid=0 has no effect.
- rd_data is sampled only during FETCH cycles for in-bounds slots.

Decomposition:
- Package nbr_pkg holds:
  - state enum {IDLE, FETCH, PRESENT, DONE}
  - slot index constants SLOT_C..SLOT_NW
  - constant arrays DR[9] and DC[9] of 2-bit signed offsets
  - window width constant WIN_W = 72
- One natural sub-module, nbr_addr_gen: combinational; inputs row, col, k; outputs address and in_bounds flag; parameterised by N and bitSize.

Test Plan:
- Preload ram[a]=a (N=8) and scan with out_ready=1 → pixel 0 window C..NW = {0,0,0,1,9,8,0,0,0}, out_addr=0, first out_valid exactly 10 cycles after start.
- Same image, pixel 9 (row 1, col 1) → window {9,1,2,10,18,17,16,8,0}. Pixel 63 → {63,55,0,0,0,0,0,62,54} with out_last=1, and done high exactly one cycle after that transfer.
- Hold out_ready=0 for 20 cycles on pixel 5 → out_window/out_addr/out_valid unchanged throughout, rd_addr frozen, no counter advance. Release → pixel 6 valid 10 cycles later.
- Pulse start while busy (pixel 12) → no effect. 64 windows and one done total; busy falls the cycle done rises.
- Assert rst for one cycle during FETCH of pixel 30 → next cycle all outputs 0 and state IDLE. A new start yields pixel 0 window again after 10 cycles.
- Toggle out_ready pseudo-randomly over a full scan → exactly 64 transfers, out_addr sequence 0..63 with none skipped or repeated, out_last only on 63.
